// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: FIFO-buffered hold/reset/set/toggle sequencer for a JK latch with synchronised readback.
// Define JK_CMD_CHECK_EN to build the expected-value compare that drives err.
module jk_cmd_driver #(
   parameter int DEPTH         = 4,
   parameter int EN_CYCLES     = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   output logic       latch_j,
   output logic       latch_k,
   output logic       latch_en,
   input  logic       latch_q,
   output logic       busy,
   output logic       done,
   output logic       done_q,
   output logic       err
);
   localparam int          AW          = $clog2(DEPTH);
   localparam int          SETTLE_TOT  = SETTLE_CYCLES + 2;
   localparam logic [AW:0] FULL_CNT    = DEPTH[AW:0];
   localparam logic [4:0]  EN_LOAD     = EN_CYCLES[4:0];
   localparam logic [4:0]  SETTLE_LOAD = SETTLE_TOT[4:0];

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [1:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_ptr_nxt;
   logic [AW:0] rd_ptr_nxt;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        settle_end;
   logic [1:0]  head;
   logic        q_meta_p0;
   logic        q_s_p1;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign settle_end = (state == SETTLE) && (cnt == 5'd1);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
   assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
   assign busy       = (state != IDLE) || !fifo_empty;

   // FIFO pointers; cmd_ready is the registered not-full of the next occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_ready <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         cmd_ready <= (wr_ptr_nxt - rd_ptr_nxt) != FULL_CNT;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= cmd;
   end

   // stage p0/p1: two-flop synchroniser for the asynchronous latch output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_meta_p0 <= 1'b0;
         q_s_p1    <= 1'b0;
      end else begin
         q_meta_p0 <= latch_q;
         q_s_p1    <= q_meta_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         latch_j  <= 1'b0;
         latch_k  <= 1'b0;
         latch_en <= 1'b0;
         done     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  state    <= DRIVE;
                  latch_j  <= head[1];
                  latch_k  <= head[0];
                  latch_en <= 1'b1;
                  // toggle gets a single-clock pulse so the latch cannot oscillate
                  cnt      <= (head == 2'b11) ? 5'd1 : EN_LOAD;
               end
            end
            DRIVE: begin
               if (cnt == 5'd1) begin
                  state    <= SETTLE;
                  latch_en <= 1'b0;
                  cnt      <= SETTLE_LOAD;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            SETTLE: begin
               if (settle_end) begin
                  state   <= CHECK;
                  done    <= 1'b1;
                  done_q  <= q_s_p1;
                  latch_j <= 1'b0;
                  latch_k <= 1'b0;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            CHECK:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef JK_CMD_CHECK_EN
   logic q_start;
   logic err_r;

   function automatic logic expected_q(input logic [1:0] op, input logic q0);
      case (op)
         2'b01:   expected_q = 1'b0;
         2'b10:   expected_q = 1'b1;
         2'b11:   expected_q = ~q0;
         default: expected_q = q0;
      endcase
   endfunction

   // j/k still hold the command on the edge that enters CHECK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_start <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         err_r <= 1'b0;
         if (pop)
            q_start <= q_s_p1;
         if (settle_end)
            err_r <= (q_s_p1 != expected_q({latch_j, latch_k}, q_start));
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: directed vector table, back-to-back FIFO fill, random scoreboard, mid-drive reset.
module tb_jk_cmd_driver;
   localparam int DEPTH  = 4;
   localparam int EN     = 2;
   localparam int SETTLE = 1;
   localparam int LAT_N  = 2 + EN + SETTLE + 2;
   localparam int LAT_T  = 2 + 1 + SETTLE + 2;
`ifdef JK_CMD_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       cmd_ready, latch_j, latch_k, latch_en, busy, done, done_q, err;
   logic       q_model = 1'b0;
   int         flip_req = 0;
   int         flip_done = 0;

   typedef struct {
      logic [1:0] c;
      bit         flip;
      int         w;
      logic       dq;
      logic       er;
      int         lat;
   } vec_t;

   typedef struct {
      logic q;
      int   w;
   } exp_t;

   vec_t tbl[12];
   exp_t sbq[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   en_run = 0;
   int   last_w = 0;
   int   en_rise_cnt = 0;
   int   done_cnt = 0;
   logic en_prev = 1'b0;
   bit   sb_on = 1'b0;
   logic sb_q = 1'b0;

   always #5 clk = ~clk;

   jk_cmd_driver #(.DEPTH(DEPTH), .EN_CYCLES(EN), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .latch_j(latch_j), .latch_k(latch_k), .latch_en(latch_en), .latch_q(q_model),
      .busy(busy), .done(done), .done_q(done_q), .err(err)
   );

   // Latch model: q follows the commanded function 1 ns after en rises; a pending flip request inverts q instead
   always @(posedge latch_en) begin
      #1;
      if (flip_req != flip_done) begin
         q_model = ~q_model;
         flip_done++;
      end else begin
         case ({latch_j, latch_k})
            2'b01:   q_model = 1'b0;
            2'b10:   q_model = 1'b1;
            2'b11:   q_model = ~q_model;
            default: q_model = q_model;
         endcase
      end
   end

   function automatic logic model_next(input logic [1:0] c, input logic q);
      if (c == 2'b11) return ~q;
      if (c == 2'b10) return 1'b1;
      if (c == 2'b01) return 1'b0;
      return q;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One negedge sample: enable-pulse bookkeeping plus the scoreboard
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (latch_en) en_run++;
      else if (en_run != 0) begin
         last_w = en_run;
         en_run = 0;
      end
      if (latch_en && !en_prev) en_rise_cnt++;
      en_prev = latch_en;
      if (done) done_cnt++;
      if (sb_on && cmd_valid && cmd_ready && rst_n) begin
         sb_q = model_next(cmd, sb_q);
         e.q = sb_q;
         e.w = (cmd == 2'b11) ? 1 : EN;
         sbq.push_back(e);
      end
      if (sb_on && done) begin
         if (sbq.size() == 0) chk("sb_pending_at_done", sbq.size(), 1);
         else begin
            e = sbq.pop_front();
            chk("sb_done_q", done_q, e.q);
            chk("sb_err", err, 0);
            chk("sb_en_width", last_w, e.w);
         end
      end
   endtask

   task automatic cyc();
      tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [1:0] c, output bit ok);
      cmd_valid = 1'b1;
      cmd = c;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (cmd_ready) ok = 1'b1;
         @(posedge clk);
         #2;
         if (ok) break;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!busy) ok = 1'b1;
         @(posedge clk);
         #2;
         if (ok) break;
      end
   endtask

   initial begin
      bit   ok;
      int   lat;
      logic bz;
      int   r4, d0, dc;

      tbl[0]  = '{2'b10, 1'b0, EN, 1'b1, 1'b0, LAT_N};
      tbl[1]  = '{2'b10, 1'b0, EN, 1'b1, 1'b0, LAT_N};
      tbl[2]  = '{2'b00, 1'b0, EN, 1'b1, 1'b0, LAT_N};
      tbl[3]  = '{2'b01, 1'b0, EN, 1'b0, 1'b0, LAT_N};
      tbl[4]  = '{2'b00, 1'b0, EN, 1'b0, 1'b0, LAT_N};
      tbl[5]  = '{2'b11, 1'b0, 1,  1'b1, 1'b0, LAT_T};
      tbl[6]  = '{2'b11, 1'b0, 1,  1'b0, 1'b0, LAT_T};
      tbl[7]  = '{2'b01, 1'b0, EN, 1'b0, 1'b0, LAT_N};
      tbl[8]  = '{2'b10, 1'b0, EN, 1'b1, 1'b0, LAT_N};
      tbl[9]  = '{2'b00, 1'b1, EN, 1'b0, CHK,  LAT_N};
      tbl[10] = '{2'b11, 1'b0, 1,  1'b1, 1'b0, LAT_T};
      tbl[11] = '{2'b01, 1'b0, EN, 1'b0, 1'b0, LAT_N};

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_latch_en", latch_en, 0);
      chk("rst_latch_j", latch_j, 0);
      chk("rst_latch_k", latch_k, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_q", done_q, 0);
      chk("rst_err", err, 0);
      #1 rst_n = 1'b1;
      #1 chk("ready_before_first_edge", cmd_ready, 0);
      @(posedge clk);
      #2;
      chk("ready_after_release", cmd_ready, 1);

      foreach (tbl[i]) begin
         if (tbl[i].flip) flip_req++;
         send(tbl[i].c, ok);
         chk("vec_accept", ok, 1);
         lat = 0;
         bz = 1'b0;
         for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) bz = busy;
            if (done) begin
               lat = k;
               break;
            end
            @(posedge clk);
            #2;
         end
         chk("vec_latency", lat, tbl[i].lat);
         chk("vec_busy_after_accept", bz, 1);
         chk("vec_done_q", done_q, tbl[i].dq);
         chk("vec_err", err, tbl[i].er);
         chk("vec_en_width", last_w, tbl[i].w);
         @(posedge clk);
         #2;
         tick();
         chk("vec_done_one_cycle", done, 0);
         chk("vec_busy_after_done", busy, 0);
         chk("vec_jk_cleared", {latch_j, latch_k}, 0);
         chk("vec_done_q_held", done_q, tbl[i].dq);
         @(posedge clk);
         #2;
         repeat (2) cyc();
      end

      // Back-to-back: one command running, then five pushes into a 4-deep FIFO
      sb_on = 1'b1;
      sb_q = q_model;
      sbq.delete();
      d0 = done_cnt;
      send(2'b10, ok);
      chk("b2b_accept0", ok, 1);
      repeat (2) cyc();
      send(2'b01, ok);
      chk("b2b_accept1", ok, 1);
      send(2'b11, ok);
      chk("b2b_accept2", ok, 1);
      send(2'b10, ok);
      chk("b2b_accept3", ok, 1);
      send(2'b00, ok);
      chk("b2b_accept4", ok, 1);
      r4 = en_rise_cnt;
      tick();
      chk("b2b_ready_low_when_full", cmd_ready, 0);
      @(posedge clk);
      #2;
      send(2'b11, ok);
      chk("b2b_accept5", ok, 1);
      chk("b2b_fifth_after_pop", int'(en_rise_cnt > r4), 1);
      wait_idle(ok);
      chk("b2b_idle", ok, 1);
      chk("b2b_done_count", done_cnt - d0, 6);
      chk("b2b_sb_empty", sbq.size(), 0);

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd = 2'($urandom_range(0, 3));
         cyc();
      end
      cmd_valid = 1'b0;
      wait_idle(ok);
      chk("rand_idle", ok, 1);
      chk("rand_sb_empty", sbq.size(), 0);
      chk("rand_ready", cmd_ready, 1);
      sb_on = 1'b0;

      // Reset while the enable pulse is high, with a second command queued
      send(2'b10, ok);
      send(2'b01, ok);
      chk("rst_mid_accept", ok, 1);
      tick();
      chk("rst_mid_en_before", latch_en, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_en_async", latch_en, 0);
      chk("rst_mid_ready", cmd_ready, 0);
      chk("rst_mid_busy", busy, 0);
      r4 = en_rise_cnt;
      dc = done_cnt;
      @(posedge clk);
      #2;
      tick();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #2;
      chk("rst_mid_ready_after", cmd_ready, 1);
      chk("rst_mid_fifo_empty", busy, 0);
      repeat (20) cyc();
      chk("rst_mid_no_done", done_cnt, dc);
      chk("rst_mid_no_replay", en_rise_cnt, r4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
